// File: rtl/trig_detect.sv
// Scope trigger detector: registers ADC samples toward the capture FIFO and fires a
// one-cycle trigger on a hysteresis-qualified level crossing, with arming and holdoff control.
module trig_detect #(
    parameter int unsigned DATA_SIZE    = 12,
    parameter int unsigned HOLD_W       = 16,
    parameter int unsigned AUTO_TIMEOUT = 4096
) (
    input  logic                 w_clk_i,
    input  logic                 rst,
    input  logic                 sample_valid_i,
    input  logic [DATA_SIZE-1:0] sample_i,
    input  logic [DATA_SIZE-1:0] level_i,
    input  logic [DATA_SIZE-1:0] hyst_i,
    input  logic                 edge_i,
    input  logic [1:0]           mode_i,
    input  logic                 arm_i,
    input  logic                 force_i,
    input  logic [HOLD_W-1:0]    holdoff_i,
    input  logic                 fifo_full_i,
    output logic [DATA_SIZE-1:0] w_data_o,
    output logic                 trigger_o,
    output logic                 armed_o,
    output logic                 busy_o
);

    localparam int unsigned AUTO_W = (AUTO_TIMEOUT > 1) ? $clog2(AUTO_TIMEOUT) : 1;
    localparam logic [AUTO_W-1:0]    AUTO_LAST = AUTO_W'(AUTO_TIMEOUT - 1);
    localparam logic [AUTO_W-1:0]    AUTO_ONE  = AUTO_W'(1);
    localparam logic [HOLD_W-1:0]    HOLD_ONE  = HOLD_W'(1);
    localparam logic [DATA_SIZE:0]   DATA_MAX  = {1'b0, {DATA_SIZE{1'b1}}};
    localparam logic [1:0]           MODE_SINGLE = 2'd0;
    localparam logic [1:0]           MODE_AUTO   = 2'd2;

    typedef enum logic [2:0] {
        StIdle,
        StArmPre,
        StArmCross,
        StCapture,
        StHoldoff
    } state_e;

    state_e              state_q, state_d;
    logic                trigger_d;
    logic [AUTO_W-1:0]   auto_cnt_q, auto_cnt_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic                full_q;
    logic                rearm_block_q, rearm_block_d;

    logic [DATA_SIZE:0]  level_x, hyst_x, sample_x, hi_sum, thr_lo, thr_hi;
    logic                left_band, crossed, full_rise, auto_wrap, auto_fire, fire;

    // Thresholds are one bit wider so the band can be clamped instead of wrapping.
    assign level_x  = {1'b0, level_i};
    assign hyst_x   = {1'b0, hyst_i};
    assign sample_x = {1'b0, sample_i};
    assign hi_sum   = level_x + hyst_x;
    assign thr_lo   = (hyst_x > level_x) ? '0 : level_x - hyst_x;
    assign thr_hi   = (hi_sum > DATA_MAX) ? DATA_MAX : hi_sum;

    assign left_band = edge_i ? (sample_x > thr_hi) : (sample_x < thr_lo);
    assign crossed   = edge_i ? (sample_i <= level_i) : (sample_i >= level_i);
    assign full_rise = fifo_full_i & ~full_q;
    assign auto_wrap = (auto_cnt_q == AUTO_LAST);
    assign auto_fire = (mode_i == MODE_AUTO) && sample_valid_i && auto_wrap;
    assign fire      = force_i || auto_fire ||
                       ((state_q == StArmCross) && sample_valid_i && crossed);

    always_comb begin
        state_d       = state_q;
        trigger_d     = 1'b0;
        auto_cnt_d    = auto_cnt_q;
        hold_cnt_d    = hold_cnt_q;
        // A completed single shot stays disarmed until arm_i is released.
        rearm_block_d = rearm_block_q & arm_i;
        unique case (state_q)
            StIdle: begin
                if (arm_i && !rearm_block_q) begin
                    state_d    = StArmPre;
                    auto_cnt_d = '0;
                end
            end
            StArmPre, StArmCross: begin
                if (!arm_i) begin
                    state_d = StIdle;
                end else if (fire) begin
                    state_d    = StCapture;
                    trigger_d  = 1'b1;
                    auto_cnt_d = '0;
                end else begin
                    if (sample_valid_i) begin
                        auto_cnt_d = auto_wrap ? '0 : auto_cnt_q + AUTO_ONE;
                    end
                    if ((state_q == StArmPre) && sample_valid_i && left_band) begin
                        state_d = StArmCross;
                    end
                end
            end
            StCapture: begin
                if (full_rise) begin
                    if (mode_i == MODE_SINGLE) begin
                        state_d       = StIdle;
                        rearm_block_d = arm_i;
                    end else begin
                        state_d    = StHoldoff;
                        hold_cnt_d = holdoff_i;
                    end
                end
            end
            StHoldoff: begin
                if ((hold_cnt_q == '0) || (sample_valid_i && (hold_cnt_q == HOLD_ONE))) begin
                    hold_cnt_d = '0;
                    if (arm_i) begin
                        state_d    = StArmPre;
                        auto_cnt_d = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (sample_valid_i) begin
                    hold_cnt_d = hold_cnt_q - HOLD_ONE;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge w_clk_i or negedge rst) begin
        if (!rst) begin
            state_q       <= StIdle;
            auto_cnt_q    <= '0;
            hold_cnt_q    <= '0;
            full_q        <= 1'b0;
            rearm_block_q <= 1'b0;
            w_data_o      <= '0;
            trigger_o     <= 1'b0;
            armed_o       <= 1'b0;
            busy_o        <= 1'b0;
        end else begin
            state_q       <= state_d;
            auto_cnt_q    <= auto_cnt_d;
            hold_cnt_q    <= hold_cnt_d;
            full_q        <= fifo_full_i;
            rearm_block_q <= rearm_block_d;
            if (sample_valid_i) begin
                w_data_o <= sample_i;
            end
            trigger_o <= trigger_d;
            armed_o   <= (state_d == StArmPre) || (state_d == StArmCross);
            busy_o    <= (state_d == StCapture) || (state_d == StHoldoff);
        end
    end

endmodule

// File: tb/tb_trig_detect.sv
// Scoreboard bench for trig_detect: a behavioural model queues the expected outputs per clock
// and an independent monitor compares them against the DUT.
module tb_trig_detect;

    localparam int DS = 12;
    localparam int HW = 16;
    localparam int AT = 16;

    localparam int M_IDLE  = 0;
    localparam int M_OUT   = 1;
    localparam int M_CROSS = 2;
    localparam int M_CAP   = 3;
    localparam int M_HOLD  = 4;

    typedef logic [DS+2:0] rec_t;   // {trigger, w_data, armed, busy}

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          sample_valid;
    logic [DS-1:0] sample, level, hyst;
    logic          edge_sel;
    logic [1:0]    mode;
    logic          arm, frc, fifo_full;
    logic [HW-1:0] holdoff;
    logic [DS-1:0] w_data;
    logic          trigger, armed, busy;

    int   checks = 0;
    int   errors = 0;
    bit   primed = 1'b0;
    rec_t exp_q[$];
    rec_t e_rec, a_rec;

    // Model state
    int            ph = M_IDLE;
    int            n_armed = 0;
    int            hold_left = 0;
    logic [DS-1:0] m_wd = '0;
    bit            m_trig = 1'b0;
    bit            fprev = 1'b0;
    bit            blocked = 1'b0;

    trig_detect #(
        .DATA_SIZE   (DS),
        .HOLD_W      (HW),
        .AUTO_TIMEOUT(AT)
    ) dut (
        .w_clk_i       (clk),
        .rst           (rst),
        .sample_valid_i(sample_valid),
        .sample_i      (sample),
        .level_i       (level),
        .hyst_i        (hyst),
        .edge_i        (edge_sel),
        .mode_i        (mode),
        .arm_i         (arm),
        .force_i       (frc),
        .holdoff_i     (holdoff),
        .fifo_full_i   (fifo_full),
        .w_data_o      (w_data),
        .trigger_o     (trigger),
        .armed_o       (armed),
        .busy_o        (busy)
    );

    always #5 clk = ~clk;

    task automatic enter_armed();
        ph      = M_OUT;
        n_armed = 0;
    endtask

    task automatic model_step();
        int s, l, lo, hi;
        bit rise, crossed, fire;
        s  = int'(sample);
        l  = int'(level);
        lo = l - int'(hyst);
        if (lo < 0) lo = 0;
        hi = l + int'(hyst);
        if (hi > 4095) hi = 4095;
        rise   = fifo_full && !fprev;
        fprev  = fifo_full;
        m_trig = 1'b0;
        if (sample_valid) m_wd = sample;
        if (!arm) blocked = 1'b0;
        case (ph)
            M_IDLE: if (arm && !blocked) enter_armed();
            M_OUT, M_CROSS: begin
                if (!arm) begin
                    ph = M_IDLE;
                end else begin
                    if (sample_valid) n_armed++;
                    crossed = sample_valid && (ph == M_CROSS) && (edge_sel ? (s <= l) : (s >= l));
                    // Auto fires on every AT-th valid sample spent armed.
                    fire = frc || crossed || ((mode == 2'd2) && sample_valid && (n_armed % AT == 0));
                    if (fire) begin
                        m_trig = 1'b1;
                        ph     = M_CAP;
                    end else if ((ph == M_OUT) && sample_valid && (edge_sel ? (s > hi) : (s < lo))) begin
                        ph = M_CROSS;
                    end
                end
            end
            M_CAP: begin
                if (rise) begin
                    if (mode == 2'd0) begin
                        ph      = M_IDLE;
                        blocked = arm;
                    end else begin
                        ph        = M_HOLD;
                        hold_left = int'(holdoff);
                    end
                end
            end
            default: begin
                if (hold_left > 0 && sample_valid) hold_left--;
                else if (hold_left > 0) hold_left = hold_left;
                if (hold_left == 0) begin
                    if (arm) enter_armed();
                    else ph = M_IDLE;
                end
            end
        endcase
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ph = M_IDLE; n_armed = 0; hold_left = 0; m_wd = '0;
            m_trig = 1'b0; fprev = 1'b0; blocked = 1'b0;
            exp_q.delete();
            if (primed || clk) begin
                exp_q.push_back('0);
                primed = 1'b1;
            end
        end else begin
            model_step();
            exp_q.push_back({m_trig, m_wd, (ph == M_OUT) || (ph == M_CROSS),
                             (ph == M_CAP) || (ph == M_HOLD)});
            primed = 1'b1;
        end
    end

    always @(negedge clk or negedge rst) begin
        if (clk === 1'b1 && rst === 1'b0) begin
            #1;
            checks++;
            a_rec = {trigger, w_data, armed, busy};
            if (a_rec !== '0) begin
                errors++;
                $display("FAIL async_reset t=%0t got trig=%0b data=%h armed=%0b busy=%0b, want all 0",
                         $time, trigger, w_data, armed, busy);
            end
        end else if (exp_q.size() == 0) begin
            if (primed) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_underflow t=%0t no expected entry for DUT output", $time);
            end
        end else begin
            e_rec = exp_q.pop_front();
            a_rec = {trigger, w_data, armed, busy};
            checks++;
            if (a_rec !== e_rec) begin
                errors++;
                $display("FAIL outputs t=%0t got trig=%0b data=%h armed=%0b busy=%0b, want trig=%0b data=%h armed=%0b busy=%0b",
                         $time, a_rec[DS+2], a_rec[DS+1:2], a_rec[1], a_rec[0],
                         e_rec[DS+2], e_rec[DS+1:2], e_rec[1], e_rec[0]);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [DS-1:0] s);
        sample_valid = 1'b1;
        sample       = s;
        cyc();
    endtask

    task automatic pulse_full(input logic [DS-1:0] s);
        fifo_full = 1'b1;
        send(s);
        fifo_full = 1'b0;
        send(s);
    endtask

    initial begin
        int tmp;
        sample_valid = 1'b0; sample = '0; level = 12'h800; hyst = 12'h010;
        edge_sel = 1'b0; mode = 2'd1; arm = 1'b0; frc = 1'b0;
        holdoff = 16'd5; fifo_full = 1'b0;
        repeat (3) cyc();
        rst = 1'b1;
        cyc();

        // Rising ramp, normal mode, then holdoff of 5 valid samples.
        arm = 1'b1;
        cyc();
        for (int v = 12'h700; v <= 12'h900; v += 12'h10) send(12'(v));
        repeat (3) send(12'h900);
        pulse_full(12'h900);
        repeat (6) send(12'h900);

        // Noise inside the band must not retrigger.
        for (int i = 0; i < 20; i++) send((i % 2) != 0 ? 12'h808 : 12'h7F8);
        send(12'h7E0);
        send(12'h800);
        repeat (3) send(12'h808);
        pulse_full(12'h808);
        repeat (6) send(12'h808);

        // Falling edge, single mode; stays idle after capture while arm held.
        arm = 1'b0;
        repeat (2) cyc();
        level = 12'h400; edge_sel = 1'b1; mode = 2'd0;
        arm = 1'b1;
        cyc();
        for (int v = 12'h600; v >= 12'h300; v -= 12'h20) send(12'(v));
        pulse_full(12'h300);
        repeat (5) send(12'h300);
        arm = 1'b0;
        cyc();

        // Auto mode with gaps in sample_valid.
        mode = 2'd2; level = 12'h800; edge_sel = 1'b0;
        arm = 1'b1;
        for (int i = 0; i < 80; i++) begin
            sample_valid = ($urandom_range(0, 3) != 0);
            sample       = 12'h100;
            fifo_full    = (i == 30);
            cyc();
        end
        fifo_full = 1'b0;
        arm = 1'b0;
        cyc();

        // Crossing and force together, then force in ARM_PRE and reset during CAPTURE.
        mode = 2'd1;
        arm  = 1'b1;
        cyc();
        send(12'h700);
        frc = 1'b1;
        send(12'h810);
        frc = 1'b0;
        repeat (2) send(12'h800);
        pulse_full(12'h800);
        repeat (7) send(12'h800);
        frc = 1'b1;
        send(12'h800);
        frc = 1'b0;
        #1 rst = 1'b0;
        repeat (2) cyc();
        rst = 1'b1;
        cyc();

        // Randomised traffic including clamped thresholds and holdoff of zero.
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) begin
                tmp = int'($urandom_range(0, 3));
                level    = (tmp == 0) ? 12'h005 : (tmp == 1) ? 12'hFFA : 12'($urandom_range(256, 3840));
                hyst     = 12'($urandom_range(0, 64));
                edge_sel = 1'($urandom_range(0, 1));
                mode     = 2'($urandom_range(0, 3));
            end
            sample_valid = ($urandom_range(0, 3) != 0);
            tmp = int'(level) + int'($urandom_range(0, 512)) - 256;
            if (tmp < 0) tmp = 0;
            if (tmp > 4095) tmp = 4095;
            sample  = 12'(tmp);
            if ($urandom_range(0, 99) < 3) arm = ~arm;
            frc     = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 9) == 0) fifo_full = ~fifo_full;
            holdoff = 16'($urandom_range(0, 7));
            cyc();
            if (i == 1500) begin
                #1 rst = 1'b0;
                cyc();
                rst = 1'b1;
            end
        end
        sample_valid = 1'b0; frc = 1'b0; arm = 1'b0;
        repeat (3) cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
